// File: rtl/mult_pkg.sv
// Shared types and sizing helpers for the sequential-multiplier control slice.
package mult_pkg;

   localparam int MULT_WIDTH = 16;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      RUN,
      DONE
   } state_t;

   // A one-bit operand still needs a one-bit counter.
   function automatic int iter_width(input int width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/mult_iter_counter.sv
// Iteration counter for the multiply loop: synchronous clear, count enable,
// and a terminal flag raised on the last iteration.
module mult_iter_counter
   import mult_pkg::*;
#(
   parameter  int WIDTH  = MULT_WIDTH,
   localparam int ITER_W = iter_width(WIDTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              enable,
   output logic [ITER_W-1:0] iter,
   output logic              last
);

   localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(WIDTH - 1);

   // NOTE: registered state is written with <= so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         iter <= '0;
      end else if (clear) begin
         iter <= '0;
      end else if (enable) begin
         iter <= iter + ITER_W'(1);
      end
   end

   assign last = (iter == LAST_ITER);

endmodule

// File: rtl/mult_controller.sv
// Control FSM for the sequential multiplier: load, WIDTH add/shift steps, then a
// valid/ack product handshake. Define MULT_EARLY_EXIT_EN to finish as soon as the
// shifted multiplier reaches zero.
module mult_controller
   import mult_pkg::*;
#(
   parameter int WIDTH = MULT_WIDTH
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   input  logic multiplier_lsb,
   input  logic count_check,
`ifdef MULT_EARLY_EXIT_EN
   input  logic multiplier_zero,
`endif
   input  logic product_ack,
   output logic load_words,
   output logic add_shift,
   output logic shift,
   output logic ready,
   output logic product_valid,
   output logic count_err
);

   localparam int ITER_W = iter_width(WIDTH);

   state_t            state;
   state_t            next_state;
   logic [ITER_W-1:0] iter;
   logic              last;
   logic              early_exit;
   logic              accept;
   logic              mismatch;

`ifdef MULT_EARLY_EXIT_EN
   assign early_exit = multiplier_zero;
`else
   assign early_exit = 1'b0;
`endif

   mult_iter_counter #(
      .WIDTH (WIDTH)
   ) u_iter_counter (
      .clk    (clk),
      .reset  (reset),
      .clear  (state == LOAD),
      .enable (state == RUN),
      .iter   (iter),
      .last   (last)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // NOTE: next_state gets a default before the case so no path infers a latch.
   always_comb begin
      next_state = state;
      unique case (state)
         IDLE: if (start) next_state = LOAD;
         LOAD: next_state = RUN;
         RUN:  if (last || early_exit) next_state = DONE;
         DONE: begin
            if (product_ack) next_state = start ? LOAD : IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      load_words    = 1'b0;
      add_shift     = 1'b0;
      shift         = 1'b0;
      ready         = 1'b0;
      product_valid = 1'b0;
      unique case (state)
         IDLE: ready = 1'b1;
         LOAD: load_words = 1'b1;
         RUN: begin
            add_shift = !early_exit &&  multiplier_lsb;
            shift     = !early_exit && !multiplier_lsb;
         end
         DONE: product_valid = 1'b1;
         default: ready = 1'b0;
      endcase
   end

   // The datapath's terminal flag must coincide with our last iteration; an early
   // exit waives the final-cycle requirement but not a premature flag.
   always_comb begin
      mismatch = 1'b0;
      if (state == RUN) begin
         mismatch = early_exit ? (count_check && !last) : (count_check != last);
      end
   end

   assign accept = start && ((state == IDLE) || ((state == DONE) && product_ack));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_err <= 1'b0;
      end else if (accept) begin
         count_err <= 1'b0;
      end else if (mismatch) begin
         count_err <= 1'b1;
      end
   end

   strobe_exclusive: assert property (@(posedge clk) disable iff (!reset)
      $onehot0({load_words, add_shift, shift}));

   iter_cleared_on_load: assert property (@(posedge clk) disable iff (!reset)
      (state == LOAD) |=> (iter == '0));

endmodule

// File: doc/mult_controller.md
Name: mult_controller

Overview:
- Control FSM directly upstream of the sequential-multiplier datapath.
- Accepts a start request, then issues load_words, followed by one add_shift or shift per multiplier bit, steered by the datapath's current multiplier LSB.
- Presents the finished product to the consumer through a valid/ack handshake.
- Cross-checks the datapath's count_check flag against its own iteration count and flags any mismatch.

Parameters:
- WIDTH, 16, operand width; number of RUN iterations.
- ITER_W, $clog2(WIDTH), iteration counter width (derived; not overridden).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  request to begin a multiply; datapath operands must be valid in the same cycle
- multiplier_lsb  in  1  bit 0 of the datapath's shifted multiplier
- count_check  in  1  datapath counter terminal flag
- product_ack  in  1  consumer has taken the product
- load_words  out  1  datapath load strobe
- add_shift  out  1  datapath add-and-shift strobe
- shift  out  1  datapath shift-only strobe
- ready  out  1  idle and able to accept start; also drives the datapath ready input
- product_valid  out  1  product is stable on the datapath output
- count_err  out  1  sticky count_check mismatch flag

Behaviour:
- States: IDLE, LOAD, RUN, DONE. Encoding is a package enum; iteration counter `iter` is ITER_W bits wide.
- While reset is low:
  - state=IDLE, iter=0, count_err=0.
  - ready=1, all other outputs 0.
  - Reset asserted mid-operation aborts immediately; no product_valid is produced.
- IDLE: ready=1. If start=1 at an edge, go to LOAD; otherwise stay. count_err clears on that same edge.
- LOAD (one cycle): load_words=1, iter<=0, then go to RUN.
- RUN (Mealy outputs):
  - add_shift = multiplier_lsb; shift = ~multiplier_lsb. Exactly one of the two is high every RUN cycle.
  - iter increments each cycle.
  - When iter==WIDTH-1, the last op is issued that cycle and the next state is DONE.
- count_check cross-check (RUN only):
  - count_check must be 1 exactly in the cycle where iter==WIDTH-1.
  - count_check=1 at any other RUN cycle, or 0 at the final cycle, sets count_err.
  - count_err is sticky until reset or the next accepted start.
- DONE:
  - product_valid=1 and ready=0. No datapath strobes are issued.
  - product_valid holds until product_ack=1; on that edge go to IDLE.
  - product_ack=1 and start=1 in the same cycle: go directly to LOAD (back-to-back); count_err clears.
- start is ignored in LOAD, RUN, and in DONE without ack.
- product_ack outside DONE is ignored.
- Latency: start sampled at edge E0 → load_words high during cycle 1 → RUN for WIDTH cycles → product_valid high after edge E(WIDTH+1). For WIDTH=16, product_valid appears 17 edges after start.
- The strobes load_words, add_shift and shift are mutually exclusive in every cycle.

Optional Feature:
- Macro: MULT_EARLY_EXIT_EN.
- Defined:
  - Adds input port multiplier_zero (1 bit): datapath shifted multiplier == 0.
  - In RUN, if multiplier_zero=1, issue no strobe that cycle, go to DONE, and skip the count_check final-cycle check. count_check=1 seen earlier in the run still sets count_err.
  - Minimum latency (multiplier=0): product_valid after edge E2.
- Undefined: the port is absent and latency is fixed at WIDTH+1.

Decomposition:
- Package mult_pkg:
  - state_t enum {IDLE, LOAD, RUN, DONE}
  - MULT_WIDTH default constant = 16
  - ITER_W derivation localparam/function
- One natural sub-module: mult_iter_counter.
  - Function: clear/enable/terminal-count counter supplying iter and the "last" flag.
  - Usage: the FSM and count_check comparison remain in mult_controller.

Test Plan:
- Reset release, start=1 one cycle, bench datapath model with multiplier 0x0005 → load_words at cycle 1; add_shift at RUN iters 0 and 2, shift at all other iters; count_check driven at iter 15 → count_err=0; product_valid rises after edge 17.
- DONE with product_ack held low 5 cycles, start pulsed during that window → product_valid stays 1, ready 0, no strobes, start ignored; ack → IDLE next edge, ready=1.
- DONE with product_ack=1 and start=1 same cycle → load_words=1 next cycle, product_valid=0, ready stays 0.
- Model pulses count_check at iter 7 → count_err=1 from next edge, held through DONE and IDLE; next accepted start → count_err=0.
- reset driven low during RUN at iter 9 → all strobes 0 and ready=1 immediately (asynchronously); after release, no product_valid appears without a new start.
- MULT_EARLY_EXIT_EN defined, multiplier 0x0003, multiplier_zero rises at RUN iter 2 → add_shift at iters 0 and 1, no strobe at iter 2, product_valid after edge 4, count_err=0.
